act_requant_writer: RTL and testbench

- Downstream writeback stage inside lenet. Consumes signed 32-bit accumulator results from the conv/FC MAC array and requantizes each to int8 using the per-layer scale (scale_CONV1..scale_FC2), with optional ReLU.
- Packs four results per 32-bit word and writes them to activation SRAM port 1, starting at a programmed word address.
- The layer controller programs it once per layer and waits for done.

---
 rtl/lenet_pkg.sv | 22 ++
 rtl/requant_unit.sv | 55 +++++
 rtl/act_requant_writer.sv | 112 +++++++++++
 tb/tb_act_requant_writer.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared constants and types for the lenet activation writeback path.
package lenet_pkg;

    localparam int SHIFT    = 16;
    localparam int INT8_MAX = 127;
    localparam int INT8_MIN = -128;

    // Per-layer requant multipliers the layer controller loads by default
    localparam int unsigned SCALE_CONV1 = 91;
    localparam int unsigned SCALE_CONV2 = 257;
    localparam int unsigned SCALE_CONV3 = 287;
    localparam int unsigned SCALE_FC1   = 427;
    localparam int unsigned SCALE_FC2   = 321;

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_e;

    // Byte enables for a word whose highest filled lane is 'lane'
    function automatic logic [3:0] lane_wea(input logic [1:0] lane);
        return {lane == 2'd3, lane >= 2'd2, lane >= 2'd1, 1'b1};
    endfunction

endpackage

// File: rtl/requant_unit.sv
// Two-stage requantizer: multiply by scale, then floor-shift, saturate to int8, optional ReLU.
module requant_unit #(
    parameter int ACC_W   = 32,
    parameter int SCALE_W = 32,
    parameter int SHIFT   = lenet_pkg::SHIFT
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    vld_i,
    input  logic signed [ACC_W-1:0] acc_i,
    input  logic [SCALE_W-1:0]      scale_i,
    input  logic                    relu_i,
    output logic                    vld_o,
    output logic [7:0]              q_o
);
    import lenet_pkg::*;

    localparam int PROD_W = ACC_W + SCALE_W;
    localparam logic signed [PROD_W-1:0] SAT_HI = PROD_W'(INT8_MAX);
    localparam logic signed [PROD_W-1:0] SAT_LO = PROD_W'(INT8_MIN);

    logic [1:0]               vld_pipe_q;
    logic signed [PROD_W-1:0] prod_q, prod_d, shifted;
    logic [7:0]               q_q, q_d;

    // Scale is unsigned: a zero sign bit keeps the multiply signed-correct
    assign prod_d  = PROD_W'($signed(acc_i)) * PROD_W'($signed({1'b0, scale_i}));
    assign shifted = prod_q >>> SHIFT;

    always_comb begin
        q_d = shifted[7:0];
        if (shifted > SAT_HI)
            q_d = 8'(INT8_MAX);
        else if (shifted < SAT_LO)
            q_d = 8'(INT8_MIN);
        if (relu_i && shifted[PROD_W-1])
            q_d = 8'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q <= '0;
            prod_q     <= '0;
            q_q        <= '0;
        end else begin
            vld_pipe_q <= {vld_pipe_q[0], vld_i};
            prod_q     <= prod_d;
            q_q        <= q_d;
        end
    end

    assign vld_o = vld_pipe_q[1];
    assign q_o   = q_q;

endmodule

// File: rtl/act_requant_writer.sv
// Layer writeback: requantizes accumulator results to int8 and packs four per SRAM word.
module act_requant_writer #(
    parameter int ACC_W   = 32,
    parameter int SCALE_W = 32,
    parameter int SHIFT   = lenet_pkg::SHIFT,
    parameter int ADDR_W  = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_start,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    input  logic [15:0]        cfg_count,
    input  logic [SCALE_W-1:0] cfg_scale,
    input  logic               cfg_relu,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [ACC_W-1:0]   in_acc,
    output logic               busy,
    output logic               done,
    output logic [3:0]         sram_act_wea1,
    output logic [ADDR_W-1:0]  sram_act_addr1,
    output logic [31:0]        sram_act_wdata1
);
    import lenet_pkg::*;

    state_e             state_q, state_d;
    logic [ADDR_W-1:0]  base_q;
    logic [15:0]        cnt_q, acc_cnt_q, out_cnt_q;
    logic [SCALE_W-1:0] scale_q;
    logic               relu_q;
    logic [31:0]        word_q, wdata_c;
    logic               accept, out_vld, last_out, wr;
    logic [7:0]         q;
    logic [1:0]         lane;

    assign in_ready = (state_q == RUN) && (acc_cnt_q < cnt_q);
    assign accept   = in_valid && in_ready;

    requant_unit #(.ACC_W(ACC_W), .SCALE_W(SCALE_W), .SHIFT(SHIFT)) u_requant (
        .clk     (clk),
        .rst_n   (rst_n),
        .vld_i   (accept),
        .acc_i   ($signed(in_acc)),
        .scale_i (scale_q),
        .relu_i  (relu_q),
        .vld_o   (out_vld),
        .q_o     (q)
    );

    // Output element index gives both the byte lane and the word offset
    assign lane     = out_cnt_q[1:0];
    assign last_out = (out_cnt_q == cnt_q - 16'd1);
    assign wr       = out_vld && (lane == 2'd3 || last_out);

    always_comb begin
        wdata_c = word_q;
        wdata_c[8*lane +: 8] = q;
    end

    assign sram_act_wea1   = wr ? lane_wea(lane) : 4'd0;
    assign sram_act_addr1  = wr ? base_q + ADDR_W'(out_cnt_q >> 2) : '0;
    assign sram_act_wdata1 = wr ? wdata_c : 32'd0;

    always_comb begin
        state_d = state_q;
        busy    = (state_q != IDLE);
        done    = (state_q == DONE);
        case (state_q)
            // An empty layer passes through FLUSH so done lands two cycles after start
            IDLE:    if (cfg_start) state_d = (cfg_count == 16'd0) ? FLUSH : RUN;
            RUN:     if (accept && acc_cnt_q == cnt_q - 16'd1) state_d = FLUSH;
            FLUSH:   if (cnt_q == 16'd0 || (out_vld && last_out)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            base_q    <= '0;
            cnt_q     <= '0;
            scale_q   <= '0;
            relu_q    <= 1'b0;
            acc_cnt_q <= '0;
            out_cnt_q <= '0;
            word_q    <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && cfg_start) begin
                base_q    <= cfg_base_addr;
                cnt_q     <= cfg_count;
                scale_q   <= cfg_scale;
                relu_q    <= cfg_relu;
                acc_cnt_q <= '0;
                out_cnt_q <= '0;
                word_q    <= '0;
            end else begin
                if (accept)
                    acc_cnt_q <= acc_cnt_q + 16'd1;
                if (out_vld) begin
                    out_cnt_q <= out_cnt_q + 16'd1;
                    if (wr)
                        word_q <= '0;
                    else
                        word_q[8*lane +: 8] <= q;
                end
            end
        end
    end

endmodule

// File: tb/tb_act_requant_writer.sv
// Directed bench for act_requant_writer with a write scoreboard and a reference requant model.
module tb_act_requant_writer;

    logic        clk, rst_n;
    logic        cfg_start, cfg_relu, in_valid, in_ready, busy, done;
    logic [15:0] cfg_base_addr, cfg_count, sram_act_addr1;
    logic [31:0] cfg_scale, in_acc, sram_act_wdata1;
    logic [3:0]  sram_act_wea1;

    typedef struct packed {
        logic [15:0] a;
        logic [3:0]  m;
        logic [31:0] d;
    } wr_t;

    wr_t  sb[$];
    int   n_checks = 0, n_fails = 0;
    int   cyc = 0, n_wr = 0, n_done = 0;
    int   last_wr_cyc = 0, last_acc_cyc = 0, done_cyc = 0, start_cyc = 0;
    logic [15:0] last_addr;
    logic [3:0]  last_wea;
    logic [31:0] last_wdata;
    int   acc_tab [16];

    act_requant_writer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cfg_start       (cfg_start),
        .cfg_base_addr   (cfg_base_addr),
        .cfg_count       (cfg_count),
        .cfg_scale       (cfg_scale),
        .cfg_relu        (cfg_relu),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_acc          (in_acc),
        .busy            (busy),
        .done            (done),
        .sram_act_wea1   (sram_act_wea1),
        .sram_act_addr1  (sram_act_addr1),
        .sram_act_wdata1 (sram_act_wdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] rq(input int acc, input int unsigned sc, input bit relu);
        longint p, r;
        p = longint'(acc) * longint'(sc);
        r = p >>> 16;
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        if (relu && r < 0) r = 0;
        return r[7:0];
    endfunction

    // Write monitor: every write must match the head of the scoreboard
    always @(negedge clk) begin
        if (done) n_done++;
        if (sram_act_wea1 != 4'd0) begin
            wr_t e;
            n_wr++;
            last_wr_cyc = cyc;
            last_addr   = sram_act_addr1;
            last_wea    = sram_act_wea1;
            last_wdata  = sram_act_wdata1;
            if (sb.size() == 0) begin
                check("unexp_write", sram_act_wea1, 4'd0);
            end else begin
                e = sb.pop_front();
                check("wr_addr", sram_act_addr1, e.a);
                check("wr_wea", sram_act_wea1, e.m);
                check("wr_data", sram_act_wdata1, e.d);
            end
        end
    end

    task automatic start(input logic [15:0] base, input logic [15:0] cnt,
                         input logic [31:0] sc, input logic relu);
        cfg_base_addr = base;
        cfg_count     = cnt;
        cfg_scale     = sc;
        cfg_relu      = relu;
        cfg_start     = 1'b1;
        start_cyc     = cyc;
        @(negedge clk);
        cfg_start = 1'b0;
    endtask

    task automatic feed(input logic [15:0] base, input int cnt, input int n,
                        input int unsigned sc, input bit relu, input int gap);
        logic [31:0] w;
        logic [3:0]  m;
        wr_t         e;
        int          t;
        w = '0;
        m = '0;
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_acc   = acc_tab[i];
            t = 0;
            while (!in_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) begin
                check("ready_timeout", in_ready, 1'b1);
                in_valid = 1'b0;
                return;
            end
            w[8*(i%4) +: 8] = rq(acc_tab[i], sc, relu);
            m[i%4] = 1'b1;
            if (i % 4 == 3 || i == cnt - 1) begin
                e.a = base + 16'(i / 4);
                e.m = m;
                e.d = w;
                sb.push_back(e);
                w = '0;
                m = '0;
            end
            last_acc_cyc = cyc;
            @(negedge clk);
            in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (!done && t < 30) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_done_seen"}, done, 1'b1);
        done_cyc = cyc;
        @(negedge clk);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout");
        $fatal(1, "bench timed out");
    end

    initial begin
        int n0, d0, s0;
        rst_n = 1'b0; cfg_start = 1'b0; cfg_base_addr = '0; cfg_count = '0;
        cfg_scale = '0; cfg_relu = 1'b0; in_valid = 1'b0; in_acc = '0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_wea", sram_act_wea1, 4'd0);
        check("rst_addr", sram_act_addr1, 16'd0);
        check("rst_wdata", sram_act_wdata1, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Full word, mixed saturation
        acc_tab[0] = 1000; acc_tab[1] = 2000000; acc_tab[2] = -2000000; acc_tab[3] = 0;
        start(16'd256, 16'd4, 32'd91, 1'b0);
        check("t1_busy", busy, 1'b1);
        feed(16'd256, 4, 4, 91, 1'b0, 0);
        wait_done("t1");
        check("t1_addr", last_addr, 16'd256);
        check("t1_wea", last_wea, 4'hF);
        check("t1_wdata", last_wdata, 32'h00807F01);
        check("t1_latency", last_wr_cyc, last_acc_cyc + 2);
        check("t1_done_timing", done_cyc, last_wr_cyc + 1);
        check("t1_idle", busy, 1'b0);

        // Floor then saturate, with and without ReLU
        acc_tab[0] = -70000;
        start(16'd40, 16'd1, 32'd257, 1'b0);
        feed(16'd40, 1, 1, 257, 1'b0, 0);
        wait_done("t2a");
        check("t2a_wdata", last_wdata, 32'h00000080);
        check("t2a_wea", last_wea, 4'b0001);
        start(16'd41, 16'd1, 32'd257, 1'b1);
        feed(16'd41, 1, 1, 257, 1'b1, 0);
        wait_done("t2b");
        check("t2b_wdata", last_wdata, 32'h00000000);
        check("t2b_addr", last_addr, 16'd41);

        // Partial final word
        for (int i = 0; i < 16; i++) acc_tab[i] = $signed($urandom) >>> 8;
        n0 = n_wr;
        start(16'd592, 16'd6, 32'd287, 1'b0);
        feed(16'd592, 6, 6, 287, 1'b0, 0);
        wait_done("t3");
        check("t3_nwrites", n_wr - n0, 2);
        check("t3_addr", last_addr, 16'd593);
        check("t3_wea", last_wea, 4'b0011);
        check("t3_done_timing", done_cyc, last_wr_cyc + 1);

        // Continuous then toggled valid over the same data
        start(16'd1000, 16'd8, 32'd427, 1'b1);
        feed(16'd1000, 8, 8, 427, 1'b1, 0);
        wait_done("t4a");
        n0 = n_wr;
        start(16'd1000, 16'd8, 32'd427, 1'b1);
        feed(16'd1000, 8, 8, 427, 1'b1, 1);
        check("t4_ready_low", in_ready, 1'b0);
        wait_done("t4b");
        check("t4_nwrites", n_wr - n0, 2);
        check("t4_done_timing", done_cyc, last_wr_cyc + 1);

        // Empty layer; second start while busy must be ignored
        n0 = n_wr;
        d0 = n_done;
        start(16'd77, 16'd0, 32'd321, 1'b0);
        s0 = start_cyc;
        check("t5_busy", busy, 1'b1);
        start(16'd78, 16'd4, 32'd321, 1'b0);
        wait_done("t5");
        check("t5_done_timing", done_cyc, s0 + 2);
        repeat (5) @(negedge clk);
        check("t5_idle", busy, 1'b0);
        check("t5_ready", in_ready, 1'b0);
        check("t5_nwrites", n_wr - n0, 0);
        check("t5_ndone", n_done - d0, 1);

        // Abort mid-layer with reset
        acc_tab[0] = 1000; acc_tab[1] = 2000000; acc_tab[2] = -2000000; acc_tab[3] = 0;
        n0 = n_wr;
        d0 = n_done;
        start(16'd10, 16'd4, 32'd91, 1'b0);
        feed(16'd10, 4, 3, 91, 1'b0, 0);
        rst_n = 1'b0;
        @(negedge clk);
        check("t6_busy", busy, 1'b0);
        check("t6_wea", sram_act_wea1, 4'd0);
        check("t6_ready", in_ready, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        check("t6_nwrites", n_wr - n0, 0);
        check("t6_ndone", n_done - d0, 0);
        start(16'd4000, 16'd4, 32'd91, 1'b0);
        feed(16'd4000, 4, 4, 91, 1'b0, 0);
        wait_done("t6");
        check("t6_wdata", last_wdata, 32'h00807F01);
        check("t6_addr", last_addr, 16'd4000);

        repeat (3) @(negedge clk);
        check("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
